// File: rtl/pc_fetch_pkg.sv
// ============================================================================
//  Module   : pc_fetch_pkg
//  Purpose  : Shared types and constants for the PC / instruction-fetch unit.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_fetch_pkg;

  // Fetch sequencer states; TRAP is only reachable with PC_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    ISSUE = 3'd3,
    TRAP  = 3'd4
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_INC    = 32'd4;

  // Force an address onto a word boundary
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_fetch_if.sv
// ============================================================================
//  Module   : pc_fetch_if
//  Purpose  : req/gnt/rvalid instruction-memory port. The fetch unit is the
//             master, the instruction memory is the slave.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/pc_plus4_adder.sv
// ============================================================================
//  Module   : pc_plus4_adder
//  Purpose  : Sequential-PC incrementer; wraps modulo 2^32 with no flag.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_plus4_adder
  import pc_fetch_pkg::*;
(
  input  wire logic [31:0] pc,
  output      logic [31:0] pc_plus4
);

  assign pc_plus4 = pc + PC_INC;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_unit.sv
// ============================================================================
//  Module   : pc_fetch_unit
//  Purpose  : Program-counter register and instruction-fetch sequencer.
//             Fetches one word per instruction over the imem port and holds
//             it on Instr until the core releases it (stall low in ISSUE).
//  Options  : PC_MISALIGN_TRAP_EN - a misaligned next PC enters a terminal
//             TRAP state instead of being silently word-aligned.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_unit
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        PCSrc,
  input  wire logic [31:0] PCTarget,
  input  wire logic        stall,
  pc_fetch_if.master       imem,
  output      logic [31:0] Instr,
  output      logic        InstrValid,
  output      logic [31:0] PC,
  output      logic [31:0] PCPlus4,
  output      logic [31:0] FetchCount,
  output      logic        misalign_trap
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic         req_q, req_d;
  logic [31:0]  count_q, count_d;
  logic         rst_sync_q;
  logic [31:0]  pc_plus4;
  logic [31:0]  next_pc_sel;
`ifdef PC_MISALIGN_TRAP_EN
  logic         trap_q, trap_d;
`endif

  pc_plus4_adder u_pc_plus4_adder (
    .pc       (pc_q),
    .pc_plus4 (pc_plus4)
  );

  // Reset is asserted asynchronously but released on a clock edge: BOOT is
  // held until this flop has seen rst_n high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 1'b0;
    else        rst_sync_q <= 1'b1;
  end

  // Next-state and next-output computation for the fetch sequencer
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    req_d       = req_q;
    count_d     = count_q;
`ifdef PC_MISALIGN_TRAP_EN
    trap_d      = trap_q;
`endif
    next_pc_sel = PCSrc ? PCTarget : pc_plus4;

    case (state_q)
      BOOT: begin
        if (rst_sync_q) begin
          state_d = REQ;
          req_d   = 1'b1;
        end
      end
      REQ: begin
        // A response arriving together with the grant is stale and dropped
        if (imem.imem_gnt) begin
          state_d = WAIT;
          req_d   = 1'b0;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          instr_d = imem.imem_rdata;
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!stall) begin
          count_d = count_q + 32'd1;
          valid_d = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
          if (next_pc_sel[1:0] != 2'b00) begin
            trap_d  = 1'b1;
            state_d = TRAP;
          end else begin
            pc_d    = next_pc_sel;
            state_d = REQ;
            req_d   = 1'b1;
          end
`else
          pc_d    = align_word(next_pc_sel);
          state_d = REQ;
          req_d   = 1'b1;
`endif
        end
      end
      default: begin
        // TRAP is terminal; only reset leaves it
      end
    endcase
  end

  // State and registered-output flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
      count_q <= 32'd0;
`ifdef PC_MISALIGN_TRAP_EN
      trap_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
      count_q <= count_d;
`ifdef PC_MISALIGN_TRAP_EN
      trap_q  <= trap_d;
`endif
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign Instr          = instr_q;
  assign InstrValid     = valid_q;
  assign PC             = pc_q;
  assign PCPlus4        = pc_plus4;
  assign FetchCount     = count_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign misalign_trap  = trap_q;
`else
  assign misalign_trap  = 1'b0;
`endif

endmodule

`default_nettype wire
